// File: rtl/bp_pkg.sv
// Shared types and constants for the branch recovery / perceptron training path.
package bp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int PC_INC = 4;
    localparam int PC_W   = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } train_entry_t;

endpackage

// File: rtl/train_buf.sv
// One-entry valid/ready register slice holding the next branch to train.
module train_buf
    import bp_pkg::*;
#(
    parameter type ENTRY_T = train_entry_t
)
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_load,
    input  ENTRY_T i_entry,
    input  logic   i_ready,
    output logic   o_valid,
    output ENTRY_T o_entry,
    output logic   o_full
);

    logic   r_full;
    ENTRY_T r_entry;

    // A load may coincide with the drain of the old entry; the load wins so the slot refills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full  <= 1'b0;
            r_entry <= '0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_entry <= i_entry;
        end else if (r_full && i_ready) begin
            r_full  <= 1'b0;
        end
    end

    assign o_valid = r_full;
    assign o_entry = r_entry;
    assign o_full  = r_full;

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Misprediction recovery sequencer: timed flush, one-shot redirect, training queue and statistics.
module branch_recovery_ctrl
    import bp_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 br_valid,
    input  logic                 br_taken,
    input  logic                 br_pred,
    input  logic                 br_low_conf,
    input  logic [WIDTH-1:0]     br_pc,
    input  logic [WIDTH-1:0]     br_target,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [WIDTH-1:0]     redirect_pc,
    output logic                 stall,
    output logic                 train_valid,
    input  logic                 train_ready,
    output logic [WIDTH-1:0]     train_pc,
    output logic                 train_taken,
    output logic [CNT_WIDTH-1:0] mispredict_cnt,
    output logic [CNT_WIDTH-1:0] branch_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic             taken;
    } entry_t;

    localparam int             FC_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FCNT_INIT = FC_W'(FLUSH_CYCLES - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [FC_W-1:0] r_fcnt;
    logic [FC_W-1:0] w_fcnt_nxt;

    logic                 w_mis;
    logic                 w_need;
    logic                 w_accept;
    logic                 w_buf_full;
    logic                 w_stall;
    entry_t               w_entry_in;
    entry_t               w_entry_out;
    logic                 r_redirect_valid;
    logic [WIDTH-1:0]     r_redirect_pc;
    logic [CNT_WIDTH-1:0] r_mis_cnt;
    logic [CNT_WIDTH-1:0] r_br_cnt;

    assign w_mis    = br_valid & (br_taken != br_pred);
    assign w_need   = br_valid & (w_mis | br_low_conf);
    // Stall only when the slot is occupied and not draining this edge; EX re-presents the branch.
    assign w_stall  = (r_state == IDLE) & w_need & w_buf_full & ~train_ready;
    assign w_accept = (r_state == IDLE) & br_valid & ~w_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            IDLE: begin
                if (w_accept && w_mis) begin
                    w_state_nxt = FLUSH;
                    w_fcnt_nxt  = FCNT_INIT;
                end
            end
            FLUSH: begin
                if (r_fcnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_fcnt_nxt = r_fcnt - 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_mis_cnt        <= '0;
            r_br_cnt         <= '0;
        end else begin
            r_redirect_valid <= w_accept & w_mis;
            if (w_accept && w_mis) begin
                r_redirect_pc <= br_taken ? br_target : br_pc + WIDTH'(PC_INC);
                r_mis_cnt     <= sat_inc(r_mis_cnt);
            end
            if (w_accept) begin
                r_br_cnt <= sat_inc(r_br_cnt);
            end
        end
    end

    assign w_entry_in.pc    = br_pc;
    assign w_entry_in.taken = br_taken;

    train_buf #(
        .ENTRY_T (entry_t)
    ) u_train_buf (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_accept & w_need),
        .i_entry (w_entry_in),
        .i_ready (train_ready),
        .o_valid (train_valid),
        .o_entry (w_entry_out),
        .o_full  (w_buf_full)
    );

    assign flush          = (r_state == FLUSH);
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign stall          = w_stall;
    assign train_pc       = w_entry_out.pc;
    assign train_taken    = w_entry_out.taken;
    assign mispredict_cnt = r_mis_cnt;
    assign branch_cnt     = r_br_cnt;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Bench for branch_recovery_ctrl: scoreboarded redirects and training entries plus direct output checks.
module tb_branch_recovery_ctrl;

    localparam int WIDTH = 32;
    localparam int FC    = 2;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             br_valid, br_taken, br_pred, br_low_conf;
    logic [WIDTH-1:0] br_pc, br_target;
    logic             flush, redirect_valid, stall, train_valid, train_ready, train_taken;
    logic [WIDTH-1:0] redirect_pc, train_pc;
    logic [CW-1:0]    mispredict_cnt, branch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] redir_q[$];
    logic [WIDTH:0]   train_q[$];

    branch_recovery_ctrl #(
        .WIDTH        (WIDTH),
        .FLUSH_CYCLES (FC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .br_pred        (br_pred),
        .br_low_conf    (br_low_conf),
        .br_pc          (br_pc),
        .br_target      (br_target),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .train_valid    (train_valid),
        .train_ready    (train_ready),
        .train_pc       (train_pc),
        .train_taken    (train_taken),
        .mispredict_cnt (mispredict_cnt),
        .branch_cnt     (branch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic v, input logic tk, input logic pr, input logic lc,
                            input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] tgt);
        br_valid    = v;
        br_taken    = tk;
        br_pred     = pr;
        br_low_conf = lc;
        br_pc       = pc;
        br_target   = tgt;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_br(0, 0, 0, 0, '0, '0);
        train_ready = 1'b0;
        redir_q.delete();
        train_q.delete();
        step();
        reset = 1'b1;
    endtask

    // Redirects and training handshakes are popped from the scoreboards as they appear.
    always @(negedge clk) begin
        logic [WIDTH-1:0] er;
        logic [WIDTH:0]   et;
        if (redirect_valid) begin
            if (redir_q.size() == 0) check("redir_unexpected", 1, 0);
            else begin
                er = redir_q.pop_front();
                check("redirect_pc", redirect_pc, er);
            end
        end
        if (train_valid && train_ready) begin
            if (train_q.size() == 0) check("train_unexpected", 1, 0);
            else begin
                et = train_q.pop_front();
                check("train_entry", {train_pc, train_taken}, et);
            end
        end
    end

    initial begin
        reset = 1'b0;
        train_ready = 1'b0;
        drive_br(0, 0, 0, 0, '0, '0);
        #2;
        check("rst_flush", flush, 0);
        check("rst_redir_v", redirect_valid, 0);
        check("rst_redir_pc", redirect_pc, 0);
        check("rst_train_v", train_valid, 0);
        check("rst_train_pc", {train_pc, train_taken}, 0);
        check("rst_cnts", {mispredict_cnt, branch_cnt}, 0);
        check("rst_stall", stall, 0);
        step();
        reset = 1'b1;
        step();

        // Not-taken predicted, taken actual; a further mispredict lands during FLUSH.
        drive_br(1, 1, 0, 0, 32'h100, 32'h200);
        #1;
        check("t1_stall", stall, 0);
        redir_q.push_back(32'h200);
        train_q.push_back({32'h100, 1'b1});
        step();
        drive_br(0, 0, 0, 0, '0, '0);
        check("t1_flush_c1", flush, 1);
        check("t1_redir_c1", redirect_valid, 1);
        check("t1_mis_cnt", mispredict_cnt, 1);
        check("t1_train_v", train_valid, 1);
        check("t1_train_ent", {train_pc, train_taken}, {32'h100, 1'b1});
        step();
        check("t1_flush_c2", flush, 1);
        check("t1_redir_c2", redirect_valid, 0);
        drive_br(1, 0, 1, 0, 32'h180, 32'h280);
        step();
        drive_br(0, 0, 0, 0, '0, '0);
        check("t4_flush_end", flush, 0);
        check("t4_redir", redirect_valid, 0);
        check("t4_cnts", {mispredict_cnt, branch_cnt}, {4'd1, 4'd1});
        train_ready = 1'b1;
        step();
        train_ready = 1'b0;
        check("t1_drained", train_valid, 0);

        // Taken predicted, not-taken actual at the top of the address space.
        drive_br(1, 0, 1, 0, 32'hFFFF_FFFC, 32'h40);
        redir_q.push_back(32'h0);
        train_q.push_back({32'hFFFF_FFFC, 1'b0});
        step();
        drive_br(0, 0, 0, 0, '0, '0);
        check("t2_redir_v", redirect_valid, 1);
        check("t2_redir_pc", redirect_pc, 32'h0);
        train_ready = 1'b1;
        step();
        train_ready = 1'b0;
        step();
        check("t2_idle", flush, 0);
        check("t2_cnts", {mispredict_cnt, branch_cnt}, {4'd2, 4'd2});

        // Low-confidence correct branch, then a second needing branch held off by back-pressure.
        do_reset();
        drive_br(1, 1, 1, 1, 32'h300, 32'h900);
        train_q.push_back({32'h300, 1'b1});
        step();
        check("t3_train_v", train_valid, 1);
        check("t3_no_flush", flush, 0);
        drive_br(1, 0, 0, 1, 32'h304, 32'h904);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_stall", stall, 1);
            step();
        end
        train_ready = 1'b1;
        #1;
        check("t3_stall_rel", stall, 0);
        train_q.push_back({32'h304, 1'b0});
        step();
        drive_br(0, 0, 0, 0, '0, '0);
        train_ready = 1'b0;
        check("t3_refill", {train_valid, train_pc, train_taken}, {1'b1, 32'h304, 1'b0});
        check("t3_br_cnt", branch_cnt, 2);
        check("t3_mis_cnt", mispredict_cnt, 0);
        train_ready = 1'b1;
        step();
        train_ready = 1'b0;
        check("t3_drained", train_valid, 0);

        // Saturation of both counters.
        do_reset();
        train_ready = 1'b1;
        for (int i = 0; i < (1 << CW) + 1; i++) begin
            drive_br(1, 1, 0, 0, 32'(i * 8), 32'(32'h1000 + i * 16));
            redir_q.push_back(32'(32'h1000 + i * 16));
            train_q.push_back({32'(i * 8), 1'b1});
            step();
            drive_br(0, 0, 0, 0, '0, '0);
            step();
            step();
            if (i == (1 << CW) - 2) check("t5_cnt_15", mispredict_cnt, 4'hF);
        end
        check("t5_mis_sat", mispredict_cnt, 4'hF);
        check("t5_br_sat", branch_cnt, 4'hF);
        train_ready = 1'b0;

        // Reset in the second FLUSH cycle with the training slot full.
        do_reset();
        drive_br(1, 1, 0, 0, 32'h500, 32'h600);
        redir_q.push_back(32'h600);
        step();
        drive_br(0, 0, 0, 0, '0, '0);
        step();
        check("t6_pre_flush", {flush, train_valid}, 2'b11);
        #2;
        reset = 1'b0;
        #1;
        check("t6_flush", flush, 0);
        check("t6_train_v", train_valid, 0);
        check("t6_cnts", {mispredict_cnt, branch_cnt}, 0);
        check("t6_redir", {redirect_valid, redirect_pc}, 0);
        step();
        reset = 1'b1;
        step();
        check("t6_idle", flush, 0);
        drive_br(1, 1, 1, 0, 32'h700, 32'h800);
        step();
        drive_br(0, 0, 0, 0, '0, '0);
        check("t6_accept", {branch_cnt, flush, train_valid}, {4'd1, 1'b0, 1'b0});

        step();
        check("redir_q_left", redir_q.size(), 0);
        check("train_q_left", train_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_recovery_ctrl.md
# branch_recovery_ctrl

Sequences misprediction recovery and perceptron training in the MIPS pipeline. It consumes each branch resolved in EX and compares the outcome against the perceptron prediction. On a mismatch it drives a timed flush of the wrong-path stages and a one-shot PC redirect. Every branch that needs training is queued through a one-entry buffer to the perceptron updater over a valid/ready handshake, and the block stalls the front end when that buffer cannot accept.

## Interface
- WIDTH, 32, PC/target width
- FLUSH_CYCLES, 2, cycles flush is held after a mispredict (≥1)
- CNT_WIDTH, 16, statistics counter width

- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- br_valid  in  1  resolved branch present in EX this cycle
- br_taken  in  1  actual outcome
- br_pred  in  1  perceptron prediction carried with the branch
- br_low_conf  in  1  perceptron |y| ≤ theta; train even if correct
- br_pc  in  WIDTH  branch PC
- br_target  in  WIDTH  taken target
- flush  out  1  clear IF/ID and ID/EX
- redirect_valid  out  1  load redirect_pc into PC (one-cycle pulse)
- redirect_pc  out  WIDTH  corrected fetch address
- stall  out  1  freeze PC, IF/ID, ID/EX, EX (branch re-presented)
- train_valid  out  1  training entry available
- train_ready  in  1  updater accepts entry
- train_pc  out  WIDTH  PC of branch to train
- train_taken  out  1  outcome to train toward
- mispredict_cnt  out  CNT_WIDTH  saturating mispredict count
- branch_cnt  out  CNT_WIDTH  saturating resolved-branch count

## Operation
- FSM states: IDLE, FLUSH. FLUSH holds a down-counter `fcnt`.
- Mispredict: `mis = br_valid & (br_taken != br_pred)`.
- Training need: `need = br_valid & (mis | br_low_conf)`.
- Accept: a branch is accepted when state is IDLE, br_valid=1 and stall=0. Only accepted branches update the counters, queue training, or trigger recovery.
- br_valid is ignored in FLUSH because EX holds wrong-path work.
- Stall: `stall = (state==IDLE) & need & buf_full & ~train_ready`. The stall is combinational. The pipeline holds EX, and the same branch is re-presented next cycle.
- Training buffer: one entry (buf_full, pc, taken).
  - train_valid = buf_full.
  - Handshake completes when train_valid & train_ready; the entry clears that edge.
  - An accepted `need` branch loads the buffer on the same edge, including the edge on which the old entry drains (pass-through refill).
  - train_pc and train_taken are stable while train_valid=1 and train_ready=0.
- Recovery on an accepted mis:
  - The next edge enters FLUSH with fcnt=FLUSH_CYCLES-1.
  - redirect_pc is latched as br_taken ? br_target : br_pc+4 (modulo 2^WIDTH).
  - redirect_valid=1 for the first FLUSH cycle only.
- FLUSH: flush=1. When fcnt==0 the FSM returns to IDLE; otherwise fcnt decrements. Training handshakes continue during FLUSH.
- Counters:
  - branch_cnt +1 per accepted branch.
  - mispredict_cnt +1 per accepted mis.
  - Both saturate at all-ones; there is no wrap.

## Timing
- Reset values: state IDLE, flush 0, redirect_valid 0, redirect_pc 0, train_valid 0, train_pc 0, train_taken 0, both counters 0, stall 0.
- Mispredict accepted at edge N → flush=1 during cycles N+1 … N+FLUSH_CYCLES; redirect_valid=1 during cycle N+1 only.
- Correct low-confidence branch: train_valid rises the cycle after acceptance; no flush.
- The buffer's drain and refill can occur on the same edge.
- Back-to-back mispredicts are impossible: the second arrives during FLUSH and is ignored.
- Reset asserted mid-FLUSH or mid-handshake: all outputs drop asynchronously and the buffered entry is discarded.
- Combinational paths: only stall depends on current inputs (br_valid, br_taken, br_pred, br_low_conf, train_ready). All other outputs are registered.

## Structure
- Shared package `bp_pkg` holds:
  - FSM state enum (IDLE, FLUSH)
  - PC increment constant 4
  - a training-entry typedef {pc, taken}
- Sub-module `train_buf`: the one-entry valid/ready register slice. It takes the entry, load and ready inputs, and outputs valid, entry and full.
- FSM, redirect logic and counters live in the top module.

## Test plan
- Mispredict, not-taken predicted, taken actual:
  - Stimulus: br_pc=0x100, br_target=0x200, FLUSH_CYCLES=2.
  - Required: redirect_valid pulse with redirect_pc=0x200; flush high 2 cycles; mispredict_cnt=1; train entry {0x100, 1}.
- Taken predicted, not-taken actual:
  - Stimulus: br_pc=0xFFFFFFFC.
  - Required: redirect_pc=0x00000000 (wrap).
- Correct branch with br_low_conf=1 and train_ready=0 for 3 cycles, then a second needing branch:
  - Required: stall=1 until train_ready=1; the second branch is accepted on the draining edge; branch_cnt=2.
- br_valid mispredicts during FLUSH:
  - Required: ignored; counters unchanged; no extra redirect.
- Counter saturation:
  - Stimulus: preload via 2^CNT_WIDTH+1 accepted mispredicts (CNT_WIDTH=4 build).
  - Required: mispredict_cnt holds at 0xF.
- Reset pulled low in the second FLUSH cycle with the buffer full:
  - Required: flush, train_valid and the counters go to 0 immediately; after release, the state is IDLE.
